// File: rtl/counter_down_timer.sv
// Programmable down-counting interval timer: loads a period on a start handshake, decrements
// once per enable, and emits a one-cycle tick at zero (periodic reload or one-shot done).
module counter_down_timer #(
    parameter int unsigned MAX   = 16,
    parameter int unsigned WIDTH = $clog2(MAX)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] period,
    input  logic             reload,
    input  logic             start,
    output logic             ready,
    input  logic             enable,
    input  logic             abort,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             m_q, m_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] period_sat;

    // Clamp only exists when the modulus leaves unused codes at the top of the bus.
    if (MAX < (2 ** WIDTH)) begin : g_sat
        localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAX - 1);
        assign period_sat = (period > QMAX) ? QMAX : period;
    end else begin : g_nosat
        assign period_sat = period;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            q_q     <= '0;
            p_q     <= '0;
            m_q     <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            p_q     <= p_d;
            m_q     <= m_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        p_d     = p_q;
        m_d     = m_q;
        tick_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    p_d     = period_sat;
                    m_d     = reload;
                    q_d     = period_sat;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (enable) begin
                    if (q_q != '0) begin
                        q_d = q_q - WIDTH'(1);
                    end else begin
                        // Terminal count: reload without a dead cycle, or park in DONE at 0.
                        tick_d = 1'b1;
                        if (m_q) begin
                            q_d = p_q;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready = (state_q == StIdle);
    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign q     = q_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_counter_down_timer.sv
// Bench for counter_down_timer: vector table applied through a scoreboard queue against two
// instances (MAX=16 and MAX=10), plus hand-written reset sequences.
module tb_counter_down_timer;

    localparam logic [2:0] IDL = 3'b001;
    localparam logic [2:0] RUN = 3'b010;
    localparam logic [2:0] DNE = 3'b100;

    typedef struct packed {
        logic [3:0] q;
        logic       tick;
        logic [2:0] st;  // {done, busy, ready}
    } exp_t;

    typedef struct {
        logic       start;
        logic [3:0] period;
        logic       reload;
        logic       enable;
        logic       abort;
        logic       ack;
        exp_t       e;
        exp_t       e10;
        bit         chk10;
    } vec_t;

    typedef struct {
        exp_t  e;
        exp_t  e10;
        bit    chk10;
        string nm;
    } sb_t;

    logic       clock;
    logic       reset;
    logic [3:0] period;
    logic       reload, start, enable, abort, ack;
    logic       ready16, tick16, busy16, done16;
    logic       ready10, tick10, busy10, done10;
    logic [3:0] q16, q10;

    int   tests;
    int   fails;
    vec_t tbl[$];
    sb_t  sbq[$];

    counter_down_timer #(.MAX(16), .WIDTH(4)) dut (
        .clock(clock), .reset(reset), .period(period), .reload(reload), .start(start),
        .ready(ready16), .enable(enable), .abort(abort), .ack(ack), .q(q16), .tick(tick16),
        .busy(busy16), .done(done16)
    );

    counter_down_timer #(.MAX(10), .WIDTH(4)) dut10 (
        .clock(clock), .reset(reset), .period(period), .reload(reload), .start(start),
        .ready(ready10), .enable(enable), .abort(abort), .ack(ack), .q(q10), .tick(tick10),
        .busy(busy10), .done(done10)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic cmp16(input string nm, input exp_t e);
        chk({nm, " q"}, 32'(q16), 32'(e.q));
        chk({nm, " tick"}, 32'(tick16), 32'(e.tick));
        chk({nm, " ready"}, 32'(ready16), 32'(e.st[0]));
        chk({nm, " busy"}, 32'(busy16), 32'(e.st[1]));
        chk({nm, " done"}, 32'(done16), 32'(e.st[2]));
    endtask

    task automatic cmp10(input string nm, input exp_t e);
        chk({nm, " m10 q"}, 32'(q10), 32'(e.q));
        chk({nm, " m10 tick"}, 32'(tick10), 32'(e.tick));
        chk({nm, " m10 ready"}, 32'(ready10), 32'(e.st[0]));
        chk({nm, " m10 busy"}, 32'(busy10), 32'(e.st[1]));
        chk({nm, " m10 done"}, 32'(done10), 32'(e.st[2]));
    endtask

    function automatic vec_t mk(input logic st, input logic [3:0] pd, input logic rl,
                                input logic en, input logic ab, input logic ak,
                                input logic [3:0] eq, input logic et, input logic [2:0] es);
        vec_t v;
        v.start  = st;
        v.period = pd;
        v.reload = rl;
        v.enable = en;
        v.abort  = ab;
        v.ack    = ak;
        v.e      = '{q: eq, tick: et, st: es};
        v.e10    = v.e;
        v.chk10  = 1'b1;
        return v;
    endfunction

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v, input string nm);
        sb_t item;
        start  = v.start;
        period = v.period;
        reload = v.reload;
        enable = v.enable;
        abort  = v.abort;
        ack    = v.ack;
        sbq.push_back('{e: v.e, e10: v.e10, chk10: v.chk10, nm: nm});
        @(posedge clock);
        #1;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s scoreboard empty got 0 want 1", nm);
        end else begin
            item = sbq.pop_front();
            cmp16(item.nm, item.e);
            if (item.chk10) cmp10(item.nm, item.e10);
        end
    endtask

    initial begin
        exp_t rst_e;
        vec_t v;
        tests  = 0;
        fails  = 0;
        reset  = 1'b0;
        start  = 1'b0;
        period = '0;
        reload = 1'b0;
        enable = 1'b0;
        abort  = 1'b0;
        ack    = 1'b0;
        rst_e  = '{q: 4'd0, tick: 1'b0, st: IDL};

        repeat (3) @(posedge clock);
        #1;
        cmp16("reset", rst_e);
        cmp10("reset", rst_e);
        #2 reset = 1'b1;

        // One-shot, period 3
        tbl.push_back(mk(1, 3, 0, 1, 0, 0, 3, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, DNE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DNE));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, DNE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, IDL));
        // Periodic, period 2, gapped enable, start while busy ignored
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 2, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, RUN));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0, 2, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, RUN));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, IDL));
        // Period 0 one-shot, ack+start in DONE, single acceptance of start
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, DNE));
        tbl.push_back(mk(1, 5, 0, 0, 0, 1, 0, 0, IDL));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDL));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0, 4, 0, RUN));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 4, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4, 0, IDL));
        // Period 0 periodic: a tick on every enabled cycle
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, IDL));
        // Abort wins over the terminal branch
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, IDL));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));

        // Period 15: MAX=16 loads 15, MAX=10 clamps to 9 and ticks on the 10th enable
        v       = mk(1, 15, 0, 0, 0, 0, 15, 0, RUN);
        v.e10   = '{q: 4'd9, tick: 1'b0, st: RUN};
        step(v, "sat load");
        for (int k = 1; k <= 10; k++) begin
            v     = mk(0, 0, 0, 1, 0, 0, 4'(15 - k), 0, RUN);
            v.e10 = (k < 10) ? '{q: 4'(9 - k), tick: 1'b0, st: RUN}
                             : '{q: 4'd0, tick: 1'b1, st: DNE};
            step(v, $sformatf("sat en%0d", k));
        end

        // Async reset between edges while the MAX=16 count sits at 5
        start  = 1'b0;
        enable = 1'b1;
        #2 reset = 1'b0;
        #1;
        cmp16("async rst", rst_e);
        cmp10("async rst", rst_e);
        repeat (2) @(posedge clock);
        #1;
        cmp16("rst held", rst_e);
        cmp10("rst held", rst_e);
        #1 reset = 1'b1;
        enable = 1'b0;
        step(mk(1, 2, 0, 0, 0, 0, 2, 0, RUN), "resume");
        step(mk(0, 0, 0, 1, 0, 0, 1, 0, RUN), "resume en");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_down_timer.md
# counter_down_timer

Programmable down-counting interval timer, the decrementing counterpart of the existing up-counter. It accepts a period through a start handshake, then counts down once per `enable`. At terminal count it emits a one-cycle `tick` and either reloads (periodic mode) or stops and holds `done` until acknowledged (one-shot mode). It sits beside the pipeline control logic for stall timeouts, multi-cycle unit sequencing and periodic events.

## Interface

Parameters:
- `MAX`, 16: counter modulus; legal count values are 0..MAX-1.
- `WIDTH`, log2(MAX): width of the count and period buses.

Ports:
- `clock`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low; asserted at 0, deasserted at 1.
- `period`  input  WIDTH  initial count, sampled only on an accepted start.
- `reload`  input  1  mode select, sampled on an accepted start: 1 = periodic, 0 = one-shot.
- `start`  input  1  start request.
- `ready`  output  1  high when a start will be accepted (state IDLE).
- `enable`  input  1  count strobe; a decrement occurs only when it is high.
- `abort`  input  1  cancels a running count.
- `ack`  input  1  clears `done`.
- `q`  output  WIDTH  current count, registered.
- `tick`  output  1  one-cycle terminal-count pulse, registered.
- `busy`  output  1  state RUN.
- `done`  output  1  state DONE (one-shot finished).

## Operation

- States: IDLE, RUN, DONE. `ready`, `busy` and `done` are one-hot decodes of the state.
- Internal registers: latched period `p`, latched mode `m`.
- IDLE:
  - start && ready: p <= sat(period), m <= reload, q <= sat(period), go to RUN.
  - Otherwise q holds its value.
- sat(x): if x > MAX-1 then MAX-1, else x. This only matters when MAX < 2**WIDTH.
- RUN, priority from highest to lowest:
  - abort: go to IDLE, q holds, no tick.
  - enable && q != 0: q <= q-1.
  - enable && q == 0: tick <= 1. If m = 1, q <= p and stay in RUN. If m = 0, go to DONE and q stays 0.
  - No enable: q holds.
- DONE:
  - ack: go to IDLE.
  - start is ignored because ready = 0. ack and start in the same cycle go to IDLE only; the start is not accepted.
  - abort has no effect.
- Period P gives a tick on the (P+1)th enabled cycle after acceptance. Period 0 ticks on the first enabled cycle.
- Periodic mode produces ticks every P+1 enabled cycles until abort.
- No wrap below 0: the decrement path never underflows, because 0 always takes the terminal branch.

## Timing

- Reset asserted forces, asynchronously: state = IDLE, q = 0, p = 0, m = 0, tick = 0. Resulting outputs: ready = 1, busy = 0, done = 0.
- Reset asserted mid-RUN or mid-DONE discards the count and any pending done with no tick. Operation resumes from IDLE on the first edge after deassertion.
- Start acceptance to busy = 1 and q = period: 1 cycle.
- tick rises on the edge where enable samples q == 0 and stays high exactly 1 cycle. In one-shot mode done rises on that same edge.
- In periodic mode, consecutive ticks with enable held high are exactly P+1 cycles apart, with no dead cycle at reload.
- abort to ready = 1: 1 cycle.
- ack to ready = 1: 1 cycle.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.

## Test plan

- Reset and one-shot: hold reset = 0 for 3 cycles. Check ready = 1 and q = 0. Release, then start with period = 3, reload = 0, enable = 1. Required: q goes 3, 2, 1, 0; tick one cycle after q = 0; done = 1 held until ack; ready = 1 the cycle after ack.
- Periodic with gaps: MAX = 16, period = 2, reload = 1, enable toggling 1, 0, 1, 0… Required: tick every 3 enabled cycles (6 clocks). q reloads to 2 on each tick. busy stays 1.
- Boundaries: period = 0 ticks on the first enable. With MAX = 10, WIDTH = 4, period = 15 loads q = 9 and needs 10 enables to tick.
- Abort at terminal: abort and enable both high with q = 0. Required: no tick, state IDLE, q = 0, done = 0.
- Handshake conflicts: start while busy is ignored (q unaffected). In DONE, start with ack goes to IDLE without loading. start while ready is accepted exactly once.
- Async reset mid-count: drop reset between clock edges while q = 5. Required: q = 0 and busy = 0 immediately, with no tick.
